sram_1r1w_bwe_byp: RTL and testbench
====================================

Name: sram_1r1w_bwe_byp

Overview:
Parametrised simple-dual-port RAM (one write port, one read port) for cache data/tag arrays, replacing fixed-geometry per-cache RAMs. Adds per-lane write enables, same-cycle read-during-write forwarding, selectable read latency (1 or 2), a read-valid strobe, and a post-reset clear sweep so arrays start zeroed. Sits directly under the D/I-cache controllers; defaults match the 257-bit × 1024-entry D-cache line store.

Parameters:
WID, 257, data width in bits
DEP, 1024, number of entries (need not be a power of 2)
AWID, $clog2(DEP), address width
LANE_WID, 8, bits per write-enable lane; NLANES = ceil(WID/LANE_WID), last lane may be partial (257 → 33 lanes, lane 32 = 1 bit)
READ_LAT, 1, read latency in cycles; legal values 1 or 2
BYPASS, 1, 1 = forward same-cycle write data to the colliding read
INIT_CLEAR, 1, 1 = zero every entry after reset before accepting traffic

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  reset, asynchronous, active-low (asserted at 0)
wr  in  1  write request
wsel  in  NLANES  lane write enables; a lane is written only when wr && wsel[k]
wadr  in  AWID  write address
i  in  WID  write data
rd  in  1  read request
radr  in  AWID  read address
o  out  WID  read data
ovalid  out  1  one-cycle strobe: o holds data for a read issued READ_LAT cycles earlier
ready  out  1  1 = clear sweep done, requests accepted

Behaviour:
- Reset (rst=0, async): o=0, ovalid=0, ready=0, sweep counter=0, pipeline valids=0. Array contents are not reset.
- FSM states: CLEAR, RUN. On reset release, enter CLEAR if INIT_CLEAR=1, otherwise RUN.
- CLEAR: writes all-ones-lane zero to address cnt each cycle, with cnt going 0..DEP-1. After writing DEP-1, go to RUN; ready=1 starting the next cycle, DEP+1 cycles after release. wr and rd are ignored, and ovalid stays 0.
- RUN: ready=1, and the FSM stays here until reset.
- RUN, if INIT_CLEAR=0: the FSM enters RUN on reset release and ready=1 on the first clock after release.
- Reset during CLEAR: the sweep restarts from 0.
- Write: in RUN, wr=1 writes lanes i[lane] where wsel=1 at wadr on that edge. wsel all-zero means no change. wadr >= DEP is dropped.
- Read: in RUN, rd=1 at edge N returns mem[radr] on o with ovalid=1 at edge N+READ_LAT. With READ_LAT=2, the second stage is an output register, and reads at back-to-back cycles stream one per cycle.
- Read with radr >= DEP returns 0 with ovalid=1.
- No read: o holds its last value (no_change), and ovalid=0.
- Collision (rd && wr && radr==wadr, same edge):
  - BYPASS=1: the result merges new i in lanes with wsel=1 and old contents elsewhere (write-first).
  - BYPASS=0: returns old contents (read-first).
- With READ_LAT=2, a write landing one cycle after the read to the same address is not forwarded; the old value is returned.
- wr and rd on different addresses are fully independent, one of each per cycle.
- Non-synthesised $display trace of each write (address, data) is kept, gated by a `define.

Decomposition:
- rfPhoenixPkg gets a typedef for lane-mask width helpers and a constant DCACHE_LANES = 33. The DCacheLine type stays where it is.
- Sub-module sram_1r1w_core holds the raw array with lane writes, a 1-cycle synchronous read and no bypass (inferable as block RAM). The top-level holds the FSM, the collision compare/merge, the latency pipeline and the range checks.

Test Plan:
- Reset release with INIT_CLEAR=1, DEP=1024 -> ready=0 for cycles 1..1024 after release, ready=1 at cycle 1025; then reads of addresses 0, 511, 1023 each return 0.
- RUN: write addr 5 with i=257'h1_DEAD…BEEF and wsel all 1; a cycle later rd addr 5 -> with READ_LAT=1, o equals the data with ovalid at the next edge; with READ_LAT=2, one edge later.
- Addr 7 = all-ones. Same edge: wr addr 7 with i=0 and wsel=33'h1 (lane 0 only), plus rd addr 7:
  - BYPASS=1 -> o = all-ones with bits[7:0]=0.
  - BYPASS=0 -> o = all-ones.
- Assert rst=0 at sweep cycle 300, release -> ready rises again exactly DEP+1 cycles after the second release; addresses 0..299 are still 0.
- READ_LAT=2, back-to-back rd of addrs 1, 2, 3 (preloaded 0x11, 0x22, 0x33) -> ovalid high 3 consecutive cycles with o = 0x11, 0x22, 0x33; o holds 0x33 afterwards with ovalid=0.
- DEP=1000: wr addr 1001 then rd addr 1001 -> o=0, ovalid=1; rd of addr 1001 mod 1000 (=1) is unchanged.

Source files
------------

// File: rtl/sram_1r1w_bwe_byp_pkg.sv
// Shared types and helpers for the lane-writable 1R1W cache RAM.
package sram_1r1w_bwe_byp_pkg;

    // Controller states: post-reset zeroing sweep, then normal traffic
    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // Lane count of the default D-cache line store (257 bits in 8-bit lanes)
    localparam int DCACHE_LANES = 33;

    // Lane mask sized for the D-cache line store
    typedef logic [DCACHE_LANES-1:0] dcache_lane_mask_t;

    // Number of write-enable lanes needed to cover wid bits; last lane may be partial
    function automatic int lanes_for(input int wid, input int lane_wid);
        return (wid + lane_wid - 1) / lane_wid;
    endfunction

endpackage

// File: rtl/sram_1r1w_bwe_byp_if.sv
// Request/response bundle between a cache controller and its 1R1W RAM.
interface sram_1r1w_bwe_byp_if
    import sram_1r1w_bwe_byp_pkg::*;
#(
    parameter int WID      = 257,
    parameter int DEP      = 1024,
    parameter int AWID     = $clog2(DEP),
    parameter int LANE_WID = 8
);
    localparam int NLANES = lanes_for(WID, LANE_WID);

    logic              wr;
    logic [NLANES-1:0] wsel;
    logic [AWID-1:0]   wadr;
    logic [WID-1:0]    i;
    logic              rd;
    logic [AWID-1:0]   radr;
    logic [WID-1:0]    o;
    logic              ovalid;
    logic              ready;

    modport master (
        output wr, wsel, wadr, i, rd, radr,
        input  o, ovalid, ready
    );

    modport slave (
        input  wr, wsel, wadr, i, rd, radr,
        output o, ovalid, ready
    );

endinterface

// File: rtl/sram_1r1w_core.sv
// Raw storage array: lane-masked write port, registered read port, no
// forwarding. Kept free of resets and muxing so it maps onto block RAM.
module sram_1r1w_core
    import sram_1r1w_bwe_byp_pkg::*;
#(
    parameter int WID      = 257,
    parameter int DEP      = 1024,
    parameter int AWID     = $clog2(DEP),
    parameter int LANE_WID = 8,
    parameter int NLANES   = lanes_for(WID, LANE_WID)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [NLANES-1:0] wlane,
    input  logic [AWID-1:0]   wadr,
    input  logic [WID-1:0]    wdata,
    input  logic              re,
    input  logic [AWID-1:0]   radr,
    output logic [WID-1:0]    rdata
);

    logic [WID-1:0] mem [DEP];
    logic [WID-1:0] wmask;

    for (genvar g = 0; g < WID; g++) begin : g_wmask
        assign wmask[g] = wlane[g / LANE_WID];
    end

    // Lane-masked write; callers guarantee wadr is in range when we is high
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wadr] <= (mem[wadr] & ~wmask) | (wdata & wmask);
        end
    end

    // Synchronous read-first read; holds the last word when not enabled
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[radr];
        end
    end

endmodule

// File: rtl/sram_1r1w_bwe_byp.sv
// Parametrised simple-dual-port cache RAM with per-lane write enables,
// same-cycle read-during-write forwarding, 1- or 2-cycle read latency and a
// post-reset zeroing sweep. Wraps sram_1r1w_core with the control logic.
module sram_1r1w_bwe_byp
    import sram_1r1w_bwe_byp_pkg::*;
#(
    parameter int WID        = 257,
    parameter int DEP        = 1024,
    parameter int AWID       = $clog2(DEP),
    parameter int LANE_WID   = 8,
    parameter int READ_LAT   = 1,
    parameter int BYPASS     = 1,
    parameter int INIT_CLEAR = 1
) (
    input logic                    clk,
    input logic                    rst,
    sram_1r1w_bwe_byp_if.slave     bus
);

    localparam int NLANES = lanes_for(WID, LANE_WID);

    state_t            state;
    state_t            state_nxt;
    logic [AWID-1:0]   cnt;
    logic [AWID-1:0]   cnt_nxt;
    logic              clr_we;
    logic              ready_q;

    logic              wr_ok;
    logic              rd_req;
    logic              rd_inr;
    logic              collide;

    logic              core_we;
    logic [NLANES-1:0] core_lane;
    logic [AWID-1:0]   core_wadr;
    logic [WID-1:0]    core_wdata;
    logic              core_re;
    logic [WID-1:0]    core_rdata;

    logic              v1;
    logic              oor1;
    logic              byp1;
    logic [NLANES-1:0] bsel1;
    logic [WID-1:0]    bdat1;
    logic [WID-1:0]    bmask1;
    logic [WID-1:0]    d1;
    logic [WID-1:0]    hold_q;

    // State register and sweep address; a reset mid-sweep restarts from entry 0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= (INIT_CLEAR != 0) ? ST_CLEAR : ST_RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Sweep one entry per cycle, then settle in RUN until the next reset
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        clr_we    = 1'b0;
        case (state)
            ST_CLEAR: begin
                clr_we = 1'b1;
                if (cnt == AWID'(DEP - 1)) begin
                    state_nxt = ST_RUN;
                end else begin
                    cnt_nxt = cnt + AWID'(1);
                end
            end
            ST_RUN: begin
                state_nxt = ST_RUN;
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    // Ready trails RUN by one cycle so traffic never overlaps the last clear write
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= (state == ST_RUN);
        end
    end

    assign bus.ready = ready_q;

    // Request qualification: out-of-range writes vanish, out-of-range reads return zero
    always_comb begin
        wr_ok   = ready_q && bus.wr && (int'(bus.wadr) < DEP);
        rd_req  = ready_q && bus.rd;
        rd_inr  = int'(bus.radr) < DEP;
        collide = wr_ok && rd_req && rd_inr && (bus.radr == bus.wadr);
    end

    // Steer the core write port between the clear sweep and user writes
    always_comb begin
        core_we    = clr_we || wr_ok;
        core_lane  = clr_we ? '1  : bus.wsel;
        core_wadr  = clr_we ? cnt : bus.wadr;
        core_wdata = clr_we ? '0  : bus.i;
        core_re    = rd_req && rd_inr;
    end

    sram_1r1w_core #(
        .WID      (WID),
        .DEP      (DEP),
        .AWID     (AWID),
        .LANE_WID (LANE_WID),
        .NLANES   (NLANES)
    ) u_core (
        .clk   (clk),
        .we    (core_we),
        .wlane (core_lane),
        .wadr  (core_wadr),
        .wdata (core_wdata),
        .re    (core_re),
        .radr  (radr_core()),
        .rdata (core_rdata)
    );

    function automatic logic [AWID-1:0] radr_core();
        return bus.radr;
    endfunction

    // First read stage: remember validity, range and any colliding write lanes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1    <= 1'b0;
            oor1  <= 1'b0;
            byp1  <= 1'b0;
            bsel1 <= '0;
            bdat1 <= '0;
        end else begin
            v1   <= rd_req;
            oor1 <= rd_req && !rd_inr;
            byp1 <= (BYPASS != 0) && collide;
            if (collide) begin
                bsel1 <= bus.wsel;
                bdat1 <= bus.i;
            end
        end
    end

    for (genvar g = 0; g < WID; g++) begin : g_bmask
        assign bmask1[g] = bsel1[g / LANE_WID];
    end

    // Merge forwarded lanes over the read-first core data; zero for bad addresses
    always_comb begin
        d1 = core_rdata;
        if (byp1) begin
            d1 = (bdat1 & bmask1) | (core_rdata & ~bmask1);
        end
        if (oor1) begin
            d1 = '0;
        end
    end

    // Last delivered word, so o holds steady between reads
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_q <= '0;
        end else if (v1) begin
            hold_q <= d1;
        end
    end

    if (READ_LAT == 2) begin : g_lat2
        logic ov_q;

        // Output-register stage: delivers stage-one data one cycle later
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                ov_q <= 1'b0;
            end else begin
                ov_q <= v1;
            end
        end

        assign bus.o      = hold_q;
        assign bus.ovalid = ov_q;
    end else begin : g_lat1
        assign bus.o      = v1 ? d1 : hold_q;
        assign bus.ovalid = v1;
    end

`ifdef SRAM_1R1W_BWE_BYP_TRACE
    // Debug trace of every accepted user write
    always @(posedge clk) begin
        if (wr_ok) begin
            $display("sram_1r1w_bwe_byp: wr adr=%0d lanes=%b data=%h", bus.wadr, bus.wsel, bus.i);
        end
    end
`endif

endmodule

// File: tb/tb_sram_1r1w_bwe_byp.sv
// Directed self-checking bench for sram_1r1w_bwe_byp. Instance A uses the
// D-cache defaults (latency 1, forwarding, clear sweep); instance B uses
// DEP=1000, latency 2, read-first collisions and no clear sweep.
module tb_sram_1r1w_bwe_byp;

    localparam logic [32:0]  ALL_LANES = '1;
    localparam logic [256:0] D_PAT     = {1'b1, {8{32'hDEAD_BEEF}}};
    localparam logic [256:0] ONES      = '1;
    localparam logic [256:0] ONES_LO0  = {{249{1'b1}}, 8'h00};
    localparam logic [256:0] LANE32    = {1'b1, 256'h0};

    logic clk;
    logic rst_a;
    logic rst_b;

    int errCount;
    int checkCount;
    int firstRise;
    int ovCount;

    sram_1r1w_bwe_byp_if #(.WID(257), .DEP(1024), .LANE_WID(8)) if_a ();
    sram_1r1w_bwe_byp_if #(.WID(257), .DEP(1000), .LANE_WID(8)) if_b ();

    sram_1r1w_bwe_byp #(
        .WID(257), .DEP(1024), .LANE_WID(8),
        .READ_LAT(1), .BYPASS(1), .INIT_CLEAR(1)
    ) u_a (
        .clk (clk),
        .rst (rst_a),
        .bus (if_a)
    );

    sram_1r1w_bwe_byp #(
        .WID(257), .DEP(1000), .LANE_WID(8),
        .READ_LAT(2), .BYPASS(0), .INIT_CLEAR(0)
    ) u_b (
        .clk (clk),
        .rst (rst_b),
        .bus (if_b)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something never completes
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [256:0] got, input logic [256:0] exp);
        checkCount++;
        if (got !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one request cycle on instance sel (0=A, 1=B) and return at the next negedge
    task automatic applyStimulus(input int sel, input logic w, input logic [32:0] ws,
                                 input logic [9:0] wa, input logic [256:0] d,
                                 input logic r, input logic [9:0] ra);
        if (sel == 0) begin
            if_a.wr = w; if_a.wsel = ws; if_a.wadr = wa; if_a.i = d;
            if_a.rd = r; if_a.radr = ra;
        end else begin
            if_b.wr = w; if_b.wsel = ws; if_b.wadr = wa; if_b.i = d;
            if_b.rd = r; if_b.radr = ra;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int sel);
        applyStimulus(sel, 1'b0, '0, '0, '0, 1'b0, '0);
    endtask

    // Count cycles after a reset release of A until ready rises, watching ovalid
    task automatic waitSweepA(output int rise, output int ovs);
        rise = 0;
        ovs  = 0;
        for (int k = 1; k <= 1100; k++) begin
            @(negedge clk);
            if (if_a.ovalid) ovs++;
            if (if_a.ready && rise == 0) begin
                rise = k;
                break;
            end
        end
    endtask

    initial begin
        errCount   = 0;
        checkCount = 0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        if_a.wr = 0; if_a.wsel = '0; if_a.wadr = '0; if_a.i = '0; if_a.rd = 0; if_a.radr = '0;
        if_b.wr = 0; if_b.wsel = '0; if_b.wadr = '0; if_b.i = '0; if_b.rd = 0; if_b.radr = '0;
        #1;
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (2) @(negedge clk);

        checkOutput("A reset ready",  257'(if_a.ready),  '0);
        checkOutput("A reset ovalid", 257'(if_a.ovalid), '0);
        checkOutput("A reset o",      if_a.o,            '0);
        checkOutput("B reset ready",  257'(if_b.ready),  '0);
        checkOutput("B reset o",      if_b.o,            '0);

        // Release both; B becomes ready after one clock, A after the sweep.
        // A sees a read request throughout the sweep, which must be ignored.
        rst_a = 1'b1;
        rst_b = 1'b1;
        if_a.rd = 1'b1;
        if_a.radr = 10'd3;
        @(negedge clk);
        checkOutput("B ready first clock", 257'(if_b.ready), 257'd1);
        checkOutput("A ready first clock", 257'(if_a.ready), 257'd0);
        waitSweepA(firstRise, ovCount);
        checkOutput("A ready rise cycle", 257'(firstRise + 1), 257'd1025);
        checkOutput("A ovalid in sweep",  257'(ovCount),       257'd0);
        if_a.rd = 1'b0;

        // Cleared array reads back zero at the ends and middle
        applyStimulus(0, 0, '0, '0, '0, 1, 10'd0);
        checkOutput("A rd0 ovalid", 257'(if_a.ovalid), 257'd1);
        checkOutput("A rd0 data",   if_a.o, '0);
        applyStimulus(0, 0, '0, '0, '0, 1, 10'd511);
        checkOutput("A rd511 data", if_a.o, '0);
        applyStimulus(0, 0, '0, '0, '0, 1, 10'd1023);
        checkOutput("A rd1023 data", if_a.o, '0);

        // Full write then read-back with latency 1
        applyStimulus(0, 1, ALL_LANES, 10'd5, D_PAT, 0, '0);
        applyStimulus(0, 0, '0, '0, '0, 1, 10'd5);
        checkOutput("A rd5 ovalid", 257'(if_a.ovalid), 257'd1);
        checkOutput("A rd5 data",   if_a.o, D_PAT);
        idle(0);
        checkOutput("A idle ovalid", 257'(if_a.ovalid), 257'd0);
        checkOutput("A idle hold",   if_a.o, D_PAT);

        // All-zero lane mask leaves the entry untouched
        applyStimulus(0, 1, '0, 10'd5, '0, 0, '0);
        applyStimulus(0, 0, '0, '0, '0, 1, 10'd5);
        checkOutput("A wsel0 nochange", if_a.o, D_PAT);

        // Collision with forwarding: lane 0 of new data merged over old contents
        applyStimulus(0, 1, ALL_LANES, 10'd7, ONES, 0, '0);
        applyStimulus(0, 1, 33'h1, 10'd7, '0, 1, 10'd7);
        checkOutput("A bypass merge", if_a.o, ONES_LO0);
        applyStimulus(0, 0, '0, '0, '0, 1, 10'd7);
        checkOutput("A after bypass", if_a.o, ONES_LO0);

        // Partial top lane covers only bit 256
        applyStimulus(0, 1, 33'h1_0000_0000, 10'd9, ONES, 0, '0);
        applyStimulus(0, 0, '0, '0, '0, 1, 10'd9);
        checkOutput("A lane32 only", if_a.o, LANE32);

        // Seed entries that the restarted sweep must zero again
        applyStimulus(0, 1, ALL_LANES, 10'd299, D_PAT, 0, '0);
        applyStimulus(0, 1, ALL_LANES, 10'd700, D_PAT, 0, '0);
        idle(0);

        // Asynchronous reset clears o and ready immediately
        rst_a = 1'b0;
        #1;
        checkOutput("A async o",     if_a.o, '0);
        checkOutput("A async ready", 257'(if_a.ready), '0);
        @(negedge clk);
        rst_a = 1'b1;
        repeat (300) @(negedge clk);
        checkOutput("A ready mid sweep", 257'(if_a.ready), '0);
        rst_a = 1'b0;
        @(negedge clk);
        rst_a = 1'b1;
        waitSweepA(firstRise, ovCount);
        checkOutput("A ready rise after restart", 257'(firstRise), 257'd1025);
        applyStimulus(0, 0, '0, '0, '0, 1, 10'd0);
        checkOutput("A restart rd0", if_a.o, '0);
        applyStimulus(0, 0, '0, '0, '0, 1, 10'd299);
        checkOutput("A restart rd299", if_a.o, '0);
        applyStimulus(0, 0, '0, '0, '0, 1, 10'd700);
        checkOutput("A restart rd700", if_a.o, '0);
        idle(0);

        // Instance B: latency 2 read-back
        applyStimulus(1, 1, ALL_LANES, 10'd5, D_PAT, 0, '0);
        applyStimulus(1, 0, '0, '0, '0, 1, 10'd5);
        checkOutput("B rd5 early ovalid", 257'(if_b.ovalid), 257'd0);
        idle(1);
        checkOutput("B rd5 ovalid", 257'(if_b.ovalid), 257'd1);
        checkOutput("B rd5 data",   if_b.o, D_PAT);

        // Read-first collision returns the old contents
        applyStimulus(1, 1, ALL_LANES, 10'd7, ONES, 0, '0);
        applyStimulus(1, 1, 33'h1, 10'd7, '0, 1, 10'd7);
        idle(1);
        checkOutput("B readfirst", if_b.o, ONES);
        applyStimulus(1, 0, '0, '0, '0, 1, 10'd7);
        idle(1);
        checkOutput("B after collide", if_b.o, ONES_LO0);

        // Write one cycle after the read is not forwarded
        applyStimulus(1, 1, ALL_LANES, 10'd8, 257'hAA, 0, '0);
        applyStimulus(1, 0, '0, '0, '0, 1, 10'd8);
        applyStimulus(1, 1, ALL_LANES, 10'd8, 257'h55, 0, '0);
        checkOutput("B late write old", if_b.o, 257'hAA);
        applyStimulus(1, 0, '0, '0, '0, 1, 10'd8);
        idle(1);
        checkOutput("B late write landed", if_b.o, 257'h55);

        // Back-to-back reads stream one per cycle
        applyStimulus(1, 1, ALL_LANES, 10'd1, 257'h11, 0, '0);
        applyStimulus(1, 1, ALL_LANES, 10'd2, 257'h22, 0, '0);
        applyStimulus(1, 1, ALL_LANES, 10'd3, 257'h33, 0, '0);
        applyStimulus(1, 0, '0, '0, '0, 1, 10'd1);
        checkOutput("B stream c0 ovalid", 257'(if_b.ovalid), 257'd0);
        applyStimulus(1, 0, '0, '0, '0, 1, 10'd2);
        checkOutput("B stream c1 data", if_b.o, 257'h11);
        checkOutput("B stream c1 ovalid", 257'(if_b.ovalid), 257'd1);
        applyStimulus(1, 0, '0, '0, '0, 1, 10'd3);
        checkOutput("B stream c2 data", if_b.o, 257'h22);
        checkOutput("B stream c2 ovalid", 257'(if_b.ovalid), 257'd1);
        idle(1);
        checkOutput("B stream c3 data", if_b.o, 257'h33);
        checkOutput("B stream c3 ovalid", 257'(if_b.ovalid), 257'd1);
        idle(1);
        checkOutput("B stream hold data", if_b.o, 257'h33);
        checkOutput("B stream hold ovalid", 257'(if_b.ovalid), 257'd0);

        // Out-of-range write dropped, out-of-range read returns zero
        applyStimulus(1, 1, ALL_LANES, 10'd1001, ONES, 0, '0);
        applyStimulus(1, 0, '0, '0, '0, 1, 10'd1001);
        idle(1);
        checkOutput("B oor ovalid", 257'(if_b.ovalid), 257'd1);
        checkOutput("B oor data",   if_b.o, '0);
        applyStimulus(1, 0, '0, '0, '0, 1, 10'd1);
        idle(1);
        checkOutput("B alias unchanged", if_b.o, 257'h11);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
